// File: rtl/char_pkg.sv
// char_pkg: shared types, screen geometry and parameter defaults for the character physics block.
// Double jump is enabled by defining CHAR_DOUBLE_JUMP_EN.
package char_pkg;
  typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} air_state_t;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_START_D = 320;
  localparam int Y_START_D = 380;
  localparam int SIZE_D = 8;
  localparam int X_STEP_D = 2;
  localparam int JUMP_SPEED_D = 4;
  localparam int JUMP_FRAMES_D = 16;
  localparam int MAX_FALL_D = 6;
  // Add in a wider signed domain so the result saturates at the edges instead of wrapping.
  function automatic logic [9:0] clamp_add(logic [9:0] pos, logic [9:0] mot, int lo, int hi);
    logic signed [11:0] s;
    s = $signed({2'b00, pos}) + $signed({{2{mot[9]}}, mot});
    return (s < 12'(lo)) ? 10'(lo) : (s > 12'(hi)) ? 10'(hi) : s[9:0];
  endfunction
endpackage

// File: rtl/frame_tick_det.sv
// frame_tick_det: one-cycle tick on each rising edge of the frame strobe.
module frame_tick_det (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic tick
);
  logic prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= 1'b0;
    else prev <= frame_clk;
  assign tick = frame_clk & ~prev;
endmodule

// File: rtl/char_physics.sv
// char_physics: per-frame walk/jump/fall motion and clamped position of the player character.
// Define CHAR_DOUBLE_JUMP_EN to allow one mid-air jump per landing.
module char_physics
  import char_pkg::*;
#(
  parameter int X_START     = X_START_D,
  parameter int Y_START     = Y_START_D,
  parameter int SIZE        = SIZE_D,
  parameter int X_STEP      = X_STEP_D,
  parameter int JUMP_SPEED  = JUMP_SPEED_D,
  parameter int JUMP_FRAMES = JUMP_FRAMES_D,
  parameter int MAX_FALL    = MAX_FALL_D
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       top_collide,
  input  logic       bottom_collide,
  input  logic       left_collide,
  input  logic       right_collide,
  output logic [9:0] Char_X_Pos,
  output logic [9:0] Char_Y_Pos,
  output logic [9:0] Char_X_Motion,
  output logic [9:0] Char_Y_Motion,
  output logic [9:0] Char_Size,
  output logic [1:0] air_state
);
  logic tick;
  air_state_t st, st_n;
  logic [9:0] cnt, cnt_n, xm_n, ym_n;
  frame_tick_det u_tick (.clk(Clk), .rst(Reset), .frame_clk(frame_clk), .tick(tick));
`ifdef CHAR_DOUBLE_JUMP_EN
  logic credit, credit_n, jump_prev;
`endif
  always_comb begin
    xm_n = (key_right & ~key_left & ~right_collide) ? 10'(X_STEP) :
           (key_left & ~key_right & ~left_collide) ? 10'(-X_STEP) : 10'd0;
    st_n = st;
    cnt_n = cnt;
    ym_n = Char_Y_Motion;
    case (st)
      GROUND: begin
        st_n = !bottom_collide ? FALL : key_jump ? RISE : GROUND;
        cnt_n = (bottom_collide & key_jump) ? 10'(JUMP_FRAMES - 1) : cnt;
        ym_n = !bottom_collide ? 10'd1 : key_jump ? 10'(-JUMP_SPEED) : 10'd0;
      end
      RISE: begin
        st_n = (top_collide || cnt == 10'd0) ? FALL : RISE;
        cnt_n = (top_collide || cnt == 10'd0) ? cnt : cnt - 10'd1;
        ym_n = (top_collide || cnt == 10'd0) ? 10'd0 : 10'(-JUMP_SPEED);
      end
      FALL: begin
        st_n = bottom_collide ? GROUND : FALL;
        ym_n = bottom_collide ? 10'd0 :
               ($signed(Char_Y_Motion) < 10'(MAX_FALL)) ? Char_Y_Motion + 10'd1 : 10'(MAX_FALL);
      end
      default: st_n = GROUND;
    endcase
`ifdef CHAR_DOUBLE_JUMP_EN
    credit_n = credit;
    // Landing and ceiling hits take precedence over the mid-air jump.
    if (st != GROUND && st_n != GROUND && !(st == RISE && top_collide) && key_jump && !jump_prev && credit) begin
      st_n = RISE;
      cnt_n = 10'(JUMP_FRAMES - 1);
      ym_n = 10'(-JUMP_SPEED);
      credit_n = 1'b0;
    end
    if (st_n == GROUND) credit_n = 1'b1;
`endif
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      Char_X_Pos <= 10'(X_START);
      Char_Y_Pos <= 10'(Y_START);
      Char_X_Motion <= 10'd0;
      Char_Y_Motion <= 10'd0;
      st <= GROUND;
      cnt <= 10'd0;
    end else if (tick) begin
      Char_X_Pos <= clamp_add(Char_X_Pos, xm_n, SIZE, SCREEN_W - 1 - SIZE);
      Char_Y_Pos <= clamp_add(Char_Y_Pos, ym_n, SIZE, SCREEN_H - 1 - SIZE);
      Char_X_Motion <= xm_n;
      Char_Y_Motion <= ym_n;
      st <= st_n;
      cnt <= cnt_n;
    end
`ifdef CHAR_DOUBLE_JUMP_EN
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      credit <= 1'b1;
      jump_prev <= 1'b0;
    end else if (tick) begin
      credit <= credit_n;
      jump_prev <= key_jump;
    end
`endif
  assign Char_Size = 10'(SIZE);
  assign air_state = st;
endmodule

// File: doc/char_physics.md
CHAR_PHYSICS -- requirements
Module: char_physics

Interface
REQ-001 SHALL have parameter X_START, default 320, reset X centre (pixels).
REQ-002 SHALL have parameter Y_START, default 380, reset Y centre (pixels).
REQ-003 SHALL have parameter SIZE, default 8, character half-width driven on Char_Size.
REQ-004 SHALL have parameter X_STEP, default 2, horizontal speed in pixels per frame.
REQ-005 SHALL have parameter JUMP_SPEED, default 4, upward speed in pixels per frame during a jump.
REQ-006 SHALL have parameter JUMP_FRAMES, default 16, maximum rise duration in frames.
REQ-007 SHALL have parameter MAX_FALL, default 6, terminal fall speed in pixels per frame.
REQ-008 SHALL have port Clk  in  1  system clock; all state changes on its rising edge.
REQ-009 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-010 SHALL have port frame_clk  in  1  vertical-sync-rate strobe, synchronous to Clk.
REQ-011 SHALL have ports key_left, key_right, key_jump  in  1 each  decoded keyboard levels.
REQ-012 SHALL have ports top_collide, bottom_collide, left_collide, right_collide  in  1 each  collision flags from the active screen's collision block.
REQ-013 SHALL have ports Char_X_Pos, Char_Y_Pos  out  10  character centre.
REQ-014 SHALL have ports Char_X_Motion, Char_Y_Motion  out  10  two's-complement per-frame velocity (Y positive = down).
REQ-015 SHALL have port Char_Size  out  10  constant SIZE.
REQ-016 SHALL have port air_state  out  2  0 GROUND, 1 RISE, 2 FALL.

Function
REQ-017 SHALL generate a one-cycle tick when frame_clk is 1 and its registered previous value is 0; all updates below occur only on tick; all outputs hold otherwise.
REQ-018 SHALL register new motion, position and state at the end of the tick cycle (1-Clk latency from frame_clk rise).
REQ-019 Horizontal: X_Motion = +X_STEP if key_right & !key_left & !right_collide; -X_STEP if key_left & !key_right & !left_collide; else 0 (both keys = 0).
REQ-020 GROUND: key_jump & bottom_collide -> RISE, counter = JUMP_FRAMES-1, Y_Motion = -JUMP_SPEED; !bottom_collide -> FALL, Y_Motion = +1 (fall takes priority over jump); else stay, Y_Motion = 0.
REQ-021 RISE: top_collide or counter = 0 -> FALL, Y_Motion = 0; else counter decrements, Y_Motion = -JUMP_SPEED; top_collide wins when top and bottom assert together.
REQ-022 FALL: bottom_collide -> GROUND, Y_Motion = 0; else Y_Motion = min(Y_Motion+1, MAX_FALL).
REQ-023 Position SHALL update with the motion computed in the same tick: Pos <= Pos + Motion, 10-bit two's-complement add.
REQ-024 X_Pos SHALL clamp to [SIZE, 639-SIZE] and Y_Pos to [SIZE, 479-SIZE]; no wrap-around.

Reset
REQ-025 Reset SHALL asynchronously force X_Pos=X_START, Y_Pos=Y_START, both motions 0, air_state GROUND, counter 0, frame_clk history 0, double-jump credit 1.
REQ-026 Reset asserted mid-jump SHALL abort the jump; the first tick after release evaluates from GROUND.

Configuration
REQ-027 Macro CHAR_DOUBLE_JUMP_EN defined: one extra jump allowed from RISE or FALL on a key_jump rising edge (sampled per tick), entering RISE as REQ-020 and clearing the credit; credit reloads on entering GROUND.
REQ-028 Macro undefined: jumps start only from GROUND; key_jump ignored in RISE and FALL.

Structure
REQ-029 Package char_pkg SHALL hold air_state_t enum, SCREEN_W=640, SCREEN_H=480, and parameter defaults.
REQ-030 Sub-module frame_tick_det SHALL implement the frame_clk edge detector of REQ-017.

Verification
REQ-031 Reset, no keys, bottom_collide=1, 3 ticks -> X=320, Y=380, air_state GROUND, motions 0.
REQ-032 key_right held 10 ticks, right_collide=0 -> X=340; then right_collide=1 one tick -> X_Motion=0, X stays 340.
REQ-033 key_jump on GROUND with bottom_collide -> RISE, Y decreases 4/tick for 16 ticks (Y=316), then FALL with Y_Motion 0,1,2..6 saturating.
REQ-034 top_collide asserted at rise tick 3 -> FALL on that tick, Y_Motion=0, Y=368.
REQ-035 Reset pulse mid-FALL at Y=200 -> immediate Y=380, GROUND, Y_Motion=0 without waiting for a tick.
REQ-036 With CHAR_DOUBLE_JUMP_EN: second key_jump edge in FALL -> RISE; third edge ignored until GROUND; without macro, second edge ignored.
